// File: rtl/cajero_pkg.sv
// Shared definitions for the ATM controller: widths, parameter defaults,
// FSM state encoding and the balance arithmetic helpers.
package cajero_pkg;

  localparam int PIN_W      = 16;
  localparam int DIGITO_W   = 4;
  localparam int MONTO_W    = 32;
  localparam int BALANCE_W  = 64;
  localparam int INTENTOS_W = 8;

  localparam logic [BALANCE_W-1:0] BALANCE_INICIAL_DEF = 64'd1_000_000_000;
  localparam logic [MONTO_W-1:0]   COMISION_AJENA_DEF  = 32'd100;
  localparam int                   MAX_INTENTOS_DEF    = 3;

  typedef enum logic [2:0] {
    ESPERA_TARJETA,
    INGRESO_PIN,
    VALIDAR_PIN,
    ESPERA_MONTO,
    PROCESAR,
    BLOQUEADO
  } estado_t;

  // Deposit never wraps: the balance clamps at the top of the 64-bit range.
  function automatic logic [BALANCE_W-1:0] suma_saturada(
    input logic [BALANCE_W-1:0] saldo,
    input logic [MONTO_W-1:0]   monto
  );
    logic [BALANCE_W:0] suma;
    suma = {1'b0, saldo} + {{(BALANCE_W-MONTO_W+1){1'b0}}, monto};
    return suma[BALANCE_W] ? {BALANCE_W{1'b1}} : suma[BALANCE_W-1:0];
  endfunction

  function automatic logic [BALANCE_W-1:0] costo_retiro(
    input logic [MONTO_W-1:0] monto,
    input logic               tarjeta_ajena,
    input logic [MONTO_W-1:0] comision
  );
    logic [BALANCE_W-1:0] fee;
    fee = tarjeta_ajena ? {{(BALANCE_W-MONTO_W){1'b0}}, comision} : '0;
    return {{(BALANCE_W-MONTO_W){1'b0}}, monto} + fee;
  endfunction

endpackage

// File: rtl/cajero_controlador_if.sv
// Card, keypad and transaction signals of the ATM controller, with the
// driving side (master) and the controller side (slave).
interface cajero_controlador_if;

  logic                            TARJETA_RECIBIDA;
  logic                            TIPO_DE_TARJETA;
  logic [cajero_pkg::PIN_W-1:0]     PIN;
  logic [cajero_pkg::DIGITO_W-1:0]  DIGITO;
  logic                            DIGITO_STB;
  logic                            TIPO_TRANS;
  logic [cajero_pkg::MONTO_W-1:0]   MONTO;
  logic                            MONTO_STB;
  logic                            BALANCE_ACTUALIZADO;
  logic                            ENTREGAR_DINERO;
  logic                            FONDOS_INSUFICIENTES;
  logic                            PIN_INCORRECTO;
  logic                            ADVERTENCIA;
  logic                            BLOQUEO;
  logic [cajero_pkg::BALANCE_W-1:0] BALANCE;

  modport master (
    output TARJETA_RECIBIDA, TIPO_DE_TARJETA, PIN, DIGITO, DIGITO_STB,
           TIPO_TRANS, MONTO, MONTO_STB,
    input  BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
           PIN_INCORRECTO, ADVERTENCIA, BLOQUEO, BALANCE
  );

  modport slave (
    input  TARJETA_RECIBIDA, TIPO_DE_TARJETA, PIN, DIGITO, DIGITO_STB,
           TIPO_TRANS, MONTO, MONTO_STB,
    output BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
           PIN_INCORRECTO, ADVERTENCIA, BLOQUEO, BALANCE
  );

endinterface

// File: rtl/detector_flanco.sv
// Rising-edge detector: flanco is high for the single cycle in which senal
// is high and was low at the previous clock edge.
module detector_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic senal,
  output logic flanco
);

  logic senal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) senal_q <= 1'b0;
    else        senal_q <= senal;
  end

  assign flanco = senal & ~senal_q;

endmodule

// File: rtl/cajero_controlador.sv
// ATM session controller: card insertion, 4-digit PIN entry with lockout,
// and a single deposit or withdrawal per validated PIN.
module cajero_controlador
  import cajero_pkg::*;
#(
  parameter logic [BALANCE_W-1:0] BALANCE_INICIAL = BALANCE_INICIAL_DEF,
  parameter logic [MONTO_W-1:0]   COMISION_AJENA  = COMISION_AJENA_DEF,
  parameter int                   MAX_INTENTOS    = MAX_INTENTOS_DEF
) (
  input logic                 CLK,
  input logic                 RESET,
  cajero_controlador_if.slave bus
);

  estado_t                 estado;
  logic [PIN_W-1:0]        pin_q;
  logic [PIN_W-1:0]        digitos;
  logic [1:0]              n_digitos;
  logic [INTENTOS_W-1:0]   intentos;
  logic                    pin_ok;
  logic [BALANCE_W-1:0]    balance_q;
  logic                    balance_act_q;
  logic                    entregar_q;
  logic                    fondos_q;
  logic                    pin_inc_q;
  logic                    advertencia_q;
  logic                    bloqueo_q;

  logic                    flanco_digito;
  logic                    flanco_monto;
  logic [PIN_W-1:0]        digitos_sig;
  logic [INTENTOS_W-1:0]   intentos_sig;
  logic [BALANCE_W-1:0]    costo;
  logic [BALANCE_W-1:0]    saldo_deposito;

  detector_flanco u_flanco_digito (
    .clk    (CLK),
    .rst_n  (RESET),
    .senal  (bus.DIGITO_STB),
    .flanco (flanco_digito)
  );

  detector_flanco u_flanco_monto (
    .clk    (CLK),
    .rst_n  (RESET),
    .senal  (bus.MONTO_STB),
    .flanco (flanco_monto)
  );

  assign digitos_sig    = {digitos[PIN_W-DIGITO_W-1:0], bus.DIGITO};
  assign intentos_sig   = intentos + 1'b1;
  assign costo          = costo_retiro(bus.MONTO, bus.TIPO_DE_TARJETA, COMISION_AJENA);
  assign saldo_deposito = suma_saturada(balance_q, bus.MONTO);

  // PIN check and transaction are resolved on the strobe edge itself, so the
  // result pulses are visible during the one-cycle VALIDAR_PIN / PROCESAR
  // state that follows; those states then only choose where to go next.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      estado        <= ESPERA_TARJETA;
      pin_q         <= '0;
      digitos       <= '0;
      n_digitos     <= '0;
      intentos      <= '0;
      pin_ok        <= 1'b0;
      balance_q     <= BALANCE_INICIAL;
      balance_act_q <= 1'b0;
      entregar_q    <= 1'b0;
      fondos_q      <= 1'b0;
      pin_inc_q     <= 1'b0;
      advertencia_q <= 1'b0;
      bloqueo_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout: every right-hand side sees the value
      // from before this edge, so the pulse defaults below are safely
      // overridden by whichever branch fires later in the block.
      balance_act_q <= 1'b0;
      entregar_q    <= 1'b0;
      fondos_q      <= 1'b0;
      pin_inc_q     <= 1'b0;

      if (estado != BLOQUEADO && !bus.TARJETA_RECIBIDA) begin
        estado <= ESPERA_TARJETA;
      end else begin
        unique case (estado)
          ESPERA_TARJETA: begin
            estado    <= INGRESO_PIN;
            pin_q     <= bus.PIN;
            digitos   <= '0;
            n_digitos <= '0;
          end

          INGRESO_PIN: begin
            if (flanco_digito) begin
              digitos   <= digitos_sig;
              n_digitos <= n_digitos + 2'd1;
              if (n_digitos == 2'd3) begin
                estado <= VALIDAR_PIN;
                pin_ok <= (digitos_sig == pin_q);
                if (digitos_sig == pin_q) begin
                  intentos      <= '0;
                  advertencia_q <= 1'b0;
                end else begin
                  pin_inc_q     <= 1'b1;
                  intentos      <= intentos_sig;
                  advertencia_q <= (intentos_sig == INTENTOS_W'(MAX_INTENTOS - 1));
                end
              end
            end
          end

          VALIDAR_PIN: begin
            n_digitos <= '0;
            if (pin_ok) begin
              estado <= ESPERA_MONTO;
            end else if (intentos >= INTENTOS_W'(MAX_INTENTOS)) begin
              estado    <= BLOQUEADO;
              bloqueo_q <= 1'b1;
            end else begin
              estado <= INGRESO_PIN;
            end
          end

          ESPERA_MONTO: begin
            if (flanco_monto) begin
              estado <= PROCESAR;
              if (!bus.TIPO_TRANS) begin
                balance_q     <= saldo_deposito;
                balance_act_q <= 1'b1;
              end else if (balance_q >= costo) begin
                balance_q     <= balance_q - costo;
                balance_act_q <= 1'b1;
                entregar_q    <= 1'b1;
              end else begin
                fondos_q <= 1'b1;
              end
            end
          end

          PROCESAR:  estado <= ESPERA_TARJETA;

          BLOQUEADO: estado <= BLOQUEADO;

          default:   estado <= ESPERA_TARJETA;
        endcase
      end
    end
  end

  assign bus.BALANCE              = balance_q;
  assign bus.BALANCE_ACTUALIZADO  = balance_act_q;
  assign bus.ENTREGAR_DINERO      = entregar_q;
  assign bus.FONDOS_INSUFICIENTES = fondos_q;
  assign bus.PIN_INCORRECTO       = pin_inc_q;
  assign bus.ADVERTENCIA          = advertencia_q;
  assign bus.BLOQUEO              = bloqueo_q;

endmodule

// File: tb/tb_cajero_controlador.sv
// Self-checking bench for cajero_controlador: directed account scenarios
// followed by randomized sessions scored against a session-level model.
module tb_cajero_controlador;
  import cajero_pkg::*;

  localparam int          MAXI = MAX_INTENTOS_DEF;
  localparam logic [63:0] BAL0 = BALANCE_INICIAL_DEF;
  localparam logic [31:0] COM  = COMISION_AJENA_DEF;
  localparam logic [63:0] MAXU = 64'hFFFF_FFFF_FFFF_FFFF;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  cajero_controlador_if bus ();

  cajero_controlador #(
    .BALANCE_INICIAL (BAL0),
    .COMISION_AJENA  (COM),
    .MAX_INTENTOS    (MAXI)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Account model: balance, wrong attempts, lockout, and whether an amount
  // is currently accepted.
  logic [63:0] m_bal;
  int          m_int;
  bit          m_bloq;
  bit          m_monto;
  bit          m_ajena;
  logic [15:0] m_pin;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tic;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_pulsos(input string tag, input bit act, input bit ent, input bit fon);
    check({tag, ".act"}, 64'(bus.BALANCE_ACTUALIZADO), 64'(act));
    check({tag, ".ent"}, 64'(bus.ENTREGAR_DINERO), 64'(ent));
    check({tag, ".fon"}, 64'(bus.FONDOS_INSUFICIENTES), 64'(fon));
  endtask

  task automatic do_reset;
    bus.TARJETA_RECIBIDA = 1'b0;
    bus.DIGITO_STB       = 1'b0;
    bus.MONTO_STB        = 1'b0;
    RESET = 1'b0;
    tic();
    m_bal = BAL0; m_int = 0; m_bloq = 0; m_monto = 0;
    check("rst.balance", bus.BALANCE, m_bal);
    check("rst.bloqueo", 64'(bus.BLOQUEO), 64'd0);
    check("rst.advertencia", 64'(bus.ADVERTENCIA), 64'd0);
    check("rst.pin_inc", 64'(bus.PIN_INCORRECTO), 64'd0);
    check_pulsos("rst", 0, 0, 0);
    RESET = 1'b1;
    tic();
  endtask

  task automatic insertar(input bit ajena, input logic [15:0] pin);
    bus.TARJETA_RECIBIDA = 1'b1;
    bus.TIPO_DE_TARJETA  = ajena;
    bus.PIN              = pin;
    m_ajena = ajena;
    m_pin   = pin;
    tic();
  endtask

  task automatic retirar;
    bus.TARJETA_RECIBIDA = 1'b0;
    m_monto = 0;
    tic();
    check("retirar.bloqueo", 64'(bus.BLOQUEO), 64'(m_bloq));
  endtask

  // Four keypad digits; the first may be held for several cycles and the
  // amount strobe may be pulsed alongside (it must have no effect here).
  task automatic teclear(input logic [15:0] teclas, input int hold, input bit dual);
    bit exp_inc;
    for (int i = 0; i < 4; i++) begin
      bus.DIGITO     = teclas[15-4*i -: 4];
      bus.DIGITO_STB = 1'b1;
      if (dual) begin
        bus.MONTO_STB  = 1'b1;
        bus.MONTO      = $urandom;
        bus.TIPO_TRANS = 1'($urandom_range(0, 1));
      end
      repeat ((i == 0) ? hold : 1) tic();
      if (i == 3) begin
        exp_inc = 0;
        if (!m_bloq) begin
          if (teclas == m_pin) begin
            m_int   = 0;
            m_monto = 1;
          end else begin
            m_int++;
            exp_inc = 1;
            if (m_int >= MAXI) m_bloq = 1;
          end
        end
        check("pin.incorrecto", 64'(bus.PIN_INCORRECTO), 64'(exp_inc));
        check("pin.advertencia", 64'(bus.ADVERTENCIA), 64'(m_int == MAXI - 1));
        check("pin.balance", bus.BALANCE, m_bal);
      end
      bus.DIGITO_STB = 1'b0;
      bus.MONTO_STB  = 1'b0;
      tic();
    end
    check("pin.bloqueo", 64'(bus.BLOQUEO), 64'(m_bloq));
    check("pin.inc_fin", 64'(bus.PIN_INCORRECTO), 64'd0);
  endtask

  task automatic operar(input bit retiro, input logic [31:0] monto);
    bit          act, ent, fon;
    logic [63:0] costo;
    act = 0; ent = 0; fon = 0;
    if (m_monto) begin
      if (!retiro) begin
        act   = 1;
        m_bal = (MAXU - m_bal < 64'(monto)) ? MAXU : m_bal + 64'(monto);
      end else begin
        costo = 64'(monto) + (m_ajena ? 64'(COM) : 64'd0);
        if (m_bal >= costo) begin
          act = 1; ent = 1;
          m_bal = m_bal - costo;
        end else begin
          fon = 1;
        end
      end
    end
    m_monto = 0;
    bus.MONTO      = monto;
    bus.TIPO_TRANS = retiro;
    bus.MONTO_STB  = 1'b1;
    tic();
    check_pulsos("op", act, ent, fon);
    check("op.balance", bus.BALANCE, m_bal);
    bus.MONTO_STB = 1'b0;
    tic();
    check_pulsos("op_fin", 0, 0, 0);
  endtask

  function automatic logic [15:0] bcd_rand();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.TARJETA_RECIBIDA = 1'b0;
    bus.TIPO_DE_TARJETA  = 1'b0;
    bus.PIN              = '0;
    bus.DIGITO           = '0;
    bus.DIGITO_STB       = 1'b0;
    bus.TIPO_TRANS       = 1'b0;
    bus.MONTO            = '0;
    bus.MONTO_STB        = 1'b0;

    do_reset();

    // Own card deposit doubling the balance.
    insertar(0, 16'h2023);
    teclear(16'h2023, 1, 0);
    operar(0, 32'd1_000_000_000);
    check("dep.balance", bus.BALANCE, 64'd2_000_000_000);
    retirar();

    // Withdrawal larger than the balance is refused.
    do_reset();
    insertar(0, 16'h2023);
    teclear(16'h2023, 1, 0);
    operar(1, 32'd1_410_065_408);
    check("insuf.balance", bus.BALANCE, 64'd1_000_000_000);
    retirar();

    // Foreign card pays the fee on top of the amount.
    do_reset();
    insertar(1, 16'h2023);
    teclear(16'h2023, 1, 0);
    operar(1, 32'd9100);
    check("ajena.balance", bus.BALANCE, 64'd999_990_800);
    retirar();

    // Three wrong PINs lock the machine until reset.
    do_reset();
    insertar(0, 16'h2023);
    teclear(16'h1111, 1, 0);
    check("lock.adv1", 64'(bus.ADVERTENCIA), 64'd0);
    teclear(16'h1111, 1, 0);
    check("lock.adv2", 64'(bus.ADVERTENCIA), 64'd1);
    teclear(16'h1111, 1, 0);
    check("lock.bloqueo", 64'(bus.BLOQUEO), 64'd1);
    teclear(16'h2023, 1, 0);
    operar(0, 32'd5);
    retirar();
    check("lock.persist", 64'(bus.BLOQUEO), 64'd1);
    do_reset();
    check("lock.cleared", 64'(bus.BLOQUEO), 64'd0);

    // A digit strobe held for five cycles is one digit.
    insertar(0, 16'h2023);
    teclear(16'h2023, 5, 1);
    operar(0, 32'd7);
    retirar();

    // Withdrawal of the whole balance empties the account.
    do_reset();
    insertar(0, 16'h2023);
    teclear(16'h2023, 1, 0);
    operar(1, 32'd1_000_000_000);
    check("vaciar.balance", bus.BALANCE, 64'd0);
    retirar();

    // Reset in the middle of PIN entry discards the partial digits.
    insertar(0, 16'h4071);
    bus.DIGITO = 4'd4; bus.DIGITO_STB = 1'b1; tic(); bus.DIGITO_STB = 1'b0; tic();
    bus.DIGITO = 4'd0; bus.DIGITO_STB = 1'b1; tic(); bus.DIGITO_STB = 1'b0; tic();
    do_reset();
    insertar(0, 16'h4071);
    teclear(16'h4071, 1, 0);
    operar(1, 32'd1);
    retirar();

    // Randomized sessions.
    for (int s = 0; s < 40; s++) begin
      logic [15:0] pin;
      logic [15:0] teclas;
      pin    = bcd_rand();
      teclas = ($urandom_range(0, 3) == 0) ? bcd_rand() : pin;
      insertar(1'($urandom_range(0, 1)), pin);
      teclear(teclas, $urandom_range(1, 3), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) != 0)
        operar(1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 400_000_000)));
      retirar();
      if (m_bloq) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cajero_controlador.md
CAJERO_CONTROLADOR -- requirements
Module: cajero_controlador

Interface
REQ-001 Timing SHALL be one clock; reset is asynchronous and active-low: CLK (rising edge), RESET (low = reset).
REQ-002 Parameter BALANCE_INICIAL, default 64'd1_000_000_000: account balance after reset.
REQ-003 Parameter COMISION_AJENA, default 32'd100: fee added to each withdrawal made with a foreign-bank card.
REQ-004 Parameter MAX_INTENTOS, default 3: wrong-PIN attempts that cause lockout.
REQ-005 CLK  in  1  system clock.
REQ-006 RESET  in  1  async active-low reset.
REQ-007 TARJETA_RECIBIDA  in  1  card present (level).
REQ-008 TIPO_DE_TARJETA  in  1  0 = own bank, 1 = foreign bank.
REQ-009 PIN  in  16  correct PIN from card, 4 BCD nibbles, first digit in [15:12].
REQ-010 DIGITO  in  4  keypad digit, valid while DIGITO_STB is high.
REQ-011 DIGITO_STB  in  1  digit strobe.
REQ-012 TIPO_TRANS  in  1  0 = deposit, 1 = withdrawal.
REQ-013 MONTO  in  32  amount, valid while MONTO_STB is high.
REQ-014 MONTO_STB  in  1  amount strobe.
REQ-015 BALANCE_ACTUALIZADO  out  1  one-cycle pulse, balance changed.
REQ-016 ENTREGAR_DINERO  out  1  one-cycle pulse, dispense cash.
REQ-017 FONDOS_INSUFICIENTES  out  1  one-cycle pulse, withdrawal refused.
REQ-018 PIN_INCORRECTO  out  1  one-cycle pulse per wrong PIN.
REQ-019 ADVERTENCIA  out  1  level, high while attempts == MAX_INTENTOS-1.
REQ-020 BLOQUEO  out  1  level, high in BLOQUEADO.
REQ-021 BALANCE  out  64  current balance register.

Function
REQ-022 FSM states SHALL be ESPERA_TARJETA, INGRESO_PIN, VALIDAR_PIN, ESPERA_MONTO, PROCESAR, BLOQUEADO.
REQ-023 Each strobe SHALL be counted once per 0->1 transition; a strobe held high for several cycles SHALL count once.
REQ-024 ESPERA_TARJETA -> INGRESO_PIN when TARJETA_RECIBIDA=1; PIN is latched internally on this transition and the digit counter is cleared.
REQ-025 In INGRESO_PIN, each DIGITO_STB edge SHALL shift DIGITO into a 16-bit register (first digit ends in [15:12]); the 4th edge -> VALIDAR_PIN.
REQ-026 In VALIDAR_PIN (one cycle): on a match, clear attempts and go to ESPERA_MONTO; on a mismatch, pulse PIN_INCORRECTO, increment attempts, and go to INGRESO_PIN, or to BLOQUEADO if attempts reaches MAX_INTENTOS.
REQ-027 Latency SHALL be as follows: PIN_INCORRECTO is asserted in the cycle after the 4th digit edge is sampled.
REQ-028 In ESPERA_MONTO, a MONTO_STB edge SHALL latch MONTO and TIPO_TRANS, then -> PROCESAR.
REQ-029 For a deposit, PROCESAR SHALL set BALANCE += MONTO (saturating at 2^64-1) and pulse BALANCE_ACTUALIZADO.
REQ-030 For a withdrawal, PROCESAR SHALL compute cost = MONTO + (TIPO_DE_TARJETA ? COMISION_AJENA : 0) in 64 bits.
REQ-031 If BALANCE >= cost, PROCESAR SHALL subtract cost from BALANCE and pulse BALANCE_ACTUALIZADO and ENTREGAR_DINERO in the same cycle; otherwise it SHALL pulse FONDOS_INSUFICIENTES and leave BALANCE unchanged.
REQ-032 PROCESAR SHALL always -> ESPERA_TARJETA; result pulses SHALL occur in the cycle after the MONTO_STB edge is sampled.
REQ-033 TARJETA_RECIBIDA=0 in any state except BLOQUEADO SHALL abort to ESPERA_TARJETA; the attempt count is kept.
REQ-034 Strobes in states that do not use them SHALL be ignored; if DIGITO_STB and MONTO_STB are simultaneous, only the strobe relevant to the current state acts.
REQ-035 BLOQUEADO SHALL be exited only by RESET; all strobes are ignored there.
REQ-036 All outputs SHALL be registered.

Reset
REQ-037 On RESET low: state = ESPERA_TARJETA, BALANCE = BALANCE_INICIAL, attempts = 0, digit count = 0, and all 1-bit outputs = 0.
REQ-038 Reset mid-session SHALL discard partial PIN digits and any pending amount.

Structure
REQ-039 Package cajero_pkg SHALL hold the state encoding, the BALANCE_INICIAL/COMISION_AJENA/MAX_INTENTOS defaults, and the widths (16, 4, 32, 64).
REQ-040 Sub-module detector_flanco SHALL provide the rising-edge detection, instantiated twice (DIGITO_STB, MONTO_STB).

Verification
REQ-041 Own card, PIN 'h2023, digits 2,0,2,3, deposit 1000000000 -> BALANCE_ACTUALIZADO pulse, BALANCE = 2000000000.
REQ-042 After reset, correct PIN, withdraw 1410065408 -> FONDOS_INSUFICIENTES pulse, BALANCE stays 1000000000, ENTREGAR_DINERO stays 0.
REQ-043 After reset, foreign card, correct PIN, withdraw 9100 -> ENTREGAR_DINERO and BALANCE_ACTUALIZADO pulse together, BALANCE = 999990800.
REQ-044 Digits 1,1,1,1 entered three times:
- 3 PIN_INCORRECTO pulses
- ADVERTENCIA high after the 2nd attempt
- BLOQUEO high after the 3rd
- correct PIN then ignored until RESET, after which BLOQUEO = 0
REQ-045 DIGITO_STB held high 5 cycles -> counts one digit.
REQ-046 Own card, withdraw exactly 1000000000 -> BALANCE = 0, ENTREGAR_DINERO pulse.
